// File: rtl/fifo_in_rotator.sv
// Write-side front end of the banked sample FIFO.
// Rotates logical lanes onto physical banks and tracks write pointer/level.
module fifo_in_rotator #(
  parameter int DATA_W          = 16,
  parameter int ADDR_W          = 11,
  parameter int NUM_OF_MEM      = 8,
  parameter int LOG2_NUM_OF_MEM = 3
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       clr_i,
  input  logic                                       valid_i,
  input  logic [LOG2_NUM_OF_MEM:0]                   cnt_i,
  input  logic [DATA_W*NUM_OF_MEM-1:0]               data_i,
  output logic                                       ready_o,
  input  logic [ADDR_W:0]                            rd_ptr_i,
  output logic [ADDR_W:0]                            wr_ptr_o,
  output logic [ADDR_W:0]                            level_o,
  output logic                                       full_o,
  output logic [NUM_OF_MEM-1:0]                      mem_we_o,
  output logic [(ADDR_W-LOG2_NUM_OF_MEM)*NUM_OF_MEM-1:0] mem_addr_o,
  output logic [DATA_W*NUM_OF_MEM-1:0]               mem_data_o,
  output logic                                       err_o
);

  localparam int L   = LOG2_NUM_OF_MEM;
  localparam int RW  = ADDR_W - L;
  localparam int CAP = 2 ** ADDR_W;

  logic [ADDR_W:0]             wr_ptr;
  logic [ADDR_W:0]             level;
  logic [L-1:0]                a;
  logic [RW-1:0]               row;
  logic                        cnt_ok;
  logic                        accept;
  logic [NUM_OF_MEM-1:0][L-1:0] lane;
  logic [NUM_OF_MEM-1:0]       we_n;
  logic [RW*NUM_OF_MEM-1:0]    addr_n;
  logic [DATA_W*NUM_OF_MEM-1:0] data_n;
  logic [NUM_OF_MEM-1:0]       mem_we;
  logic [RW*NUM_OF_MEM-1:0]    mem_addr;
  logic [DATA_W*NUM_OF_MEM-1:0] mem_data;
  logic                        err;

  assign a     = wr_ptr[L-1:0];
  assign row   = wr_ptr[ADDR_W-1:L];
  assign level = wr_ptr - rd_ptr_i;

  // Comparing level against CAP-NUM avoids underflow if level ever exceeds CAP.
  assign ready_o = !rst_i && !clr_i &&
                   (level <= (ADDR_W+1)'(CAP - NUM_OF_MEM));
  assign full_o  = (level == (ADDR_W+1)'(CAP));

  assign cnt_ok = (cnt_i != '0) &&
                  (cnt_i <= (L+1)'(NUM_OF_MEM));
  assign accept = valid_i && ready_o && cnt_ok;

  // Per-bank lane select, enable and row (banks below a carry into next row).
  always_comb begin
    lane   = '0;
    we_n   = '0;
    addr_n = '0;
    data_n = '0;
    for (int p = 0; p < NUM_OF_MEM; p++) begin
      lane[p] = L'(p) - a;
      we_n[p] = {1'b0, lane[p]} < cnt_i;
      data_n[DATA_W*p +: DATA_W] = data_i[DATA_W*lane[p] +: DATA_W];
      addr_n[RW*p +: RW] = row + RW'(L'(p) < a);
    end
  end

  // Registered bank writes, pointer advance and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr   <= '0;
      mem_we   <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      err      <= 1'b0;
    end else begin
      mem_we <= accept ? we_n : '0;
      if (accept) begin
        mem_addr <= addr_n;
        mem_data <= data_n;
        wr_ptr   <= wr_ptr + (ADDR_W+1)'(cnt_i);
      end
      if (valid_i && !cnt_ok)
        err <= 1'b1;
    end
  end

  assign wr_ptr_o   = wr_ptr;
  assign level_o    = level;
  assign mem_we_o   = mem_we;
  assign mem_addr_o = mem_addr;
  assign mem_data_o = mem_data;
  assign err_o      = err;

endmodule

// File: tb/tb_fifo_in_rotator.sv
// Testbench for fifo_in_rotator.
// Directed and random words checked against a sample-address model.
module tb_fifo_in_rotator;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         clr_i = 1'b0;
  logic         valid_i = 1'b0;
  logic [3:0]   cnt_i = '0;
  logic [127:0] data_i = '0;
  logic         ready_o;
  logic [11:0]  rd_ptr = '0;
  logic [11:0]  wr_ptr_o;
  logic [11:0]  level_o;
  logic         full_o;
  logic [7:0]   mem_we_o;
  logic [63:0]  mem_addr_o;
  logic [127:0] mem_data_o;
  logic         err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int m_wp    = 0;
  bit m_err   = 0;

  fifo_in_rotator dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .clr_i      (clr_i),
    .valid_i    (valid_i),
    .cnt_i      (cnt_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .rd_ptr_i   (rd_ptr),
    .wr_ptr_o   (wr_ptr_o),
    .level_o    (level_o),
    .full_o     (full_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int mlevel();
    return (m_wp - int'(rd_ptr)) & 4095;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input int cnt, input logic [127:0] d);
    bit          legal;
    bit          rdy;
    bit          acc;
    int          s;
    logic [7:0]  ew;
    logic [63:0] ea;
    logic [127:0] ed;
    valid_i = 1'b1;
    cnt_i   = 4'(cnt);
    data_i  = d;
    #1;
    legal = (cnt >= 1) && (cnt <= 8);
    rdy   = mlevel() <= 2040;
    acc   = legal && rdy;
    chk("ready", 128'(ready_o), 128'(rdy));
    ew = '0;
    ea = '0;
    ed = '0;
    for (int i = 0; i < 8; i++) begin
      s = (m_wp + i) % 2048;
      ea[8*(s%8) +: 8]   = 8'(s / 8);
      ed[16*(s%8) +: 16] = d[16*i +: 16];
      if (i < cnt) ew[s%8] = 1'b1;
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    if (acc) m_wp = (m_wp + cnt) % 4096;
    if (!legal) m_err = 1'b1;
    chk("we", 128'(mem_we_o), acc ? 128'(ew) : 128'(0));
    if (acc) begin
      chk("addr", 128'(mem_addr_o), 128'(ea));
      chk("data", mem_data_o, ed);
    end
    chk("wr_ptr", 128'(wr_ptr_o), 128'(m_wp));
    chk("level", 128'(level_o), 128'(mlevel()));
    chk("full", 128'(full_o), 128'(mlevel() == 2048));
    chk("err", 128'(err_o), 128'(m_err));
  endtask

  task automatic do_clr();
    clr_i   = 1'b1;
    valid_i = 1'b1;
    cnt_i   = 4'd8;
    #1;
    chk("clr_ready", 128'(ready_o), 128'(0));
    @(posedge clk);
    #1;
    m_wp  = 0;
    m_err = 1'b0;
    chk("clr_we", 128'(mem_we_o), 128'(0));
    chk("clr_wr_ptr", 128'(wr_ptr_o), 128'(0));
    chk("clr_err", 128'(err_o), 128'(0));
    clr_i   = 1'b0;
    valid_i = 1'b0;
  endtask

  initial begin
    logic [127:0] d;
    int c;

    // 1 reset with valid held high
    rst_i   = 1'b1;
    valid_i = 1'b1;
    cnt_i   = 4'd8;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 128'(mem_we_o), 128'(0));
    chk("rst_wr_ptr", 128'(wr_ptr_o), 128'(0));
    chk("rst_level", 128'(level_o), 128'(0));
    chk("rst_err", 128'(err_o), 128'(0));
    chk("rst_ready", 128'(ready_o), 128'(0));
    rst_i   = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("post_rst_ready", 128'(ready_o), 128'(1));

    // 2 aligned full word
    for (int i = 0; i < 8; i++) d[16*i +: 16] = 16'(16'h100 + i);
    send(8, d);
    chk("aligned_we", 128'(mem_we_o), 128'(8'hFF));
    chk("aligned_data", mem_data_o, d);
    chk("aligned_addr", 128'(mem_addr_o), 128'(0));
    chk("aligned_wp", 128'(wr_ptr_o), 128'(8));

    // 3 unaligned partial words
    do_clr();
    send(6, rnd128());
    d = '0;
    for (int i = 0; i < 4; i++) d[16*i +: 16] = 16'(16'hA0 + i);
    send(4, d);
    chk("unal_we", 128'(mem_we_o), 128'(8'hC3));
    chk("unal_b6", 128'(mem_data_o[16*6 +: 16]), 128'(16'hA0));
    chk("unal_b7", 128'(mem_data_o[16*7 +: 16]), 128'(16'hA1));
    chk("unal_b0", 128'(mem_data_o[15:0]), 128'(16'hA2));
    chk("unal_b1", 128'(mem_data_o[31:16]), 128'(16'hA3));
    chk("unal_r6", 128'(mem_addr_o[55:48]), 128'(0));
    chk("unal_r0", 128'(mem_addr_o[7:0]), 128'(1));
    chk("unal_wp", 128'(wr_ptr_o), 128'(10));

    // 4 backpressure at level 2041
    rd_ptr = '0;
    while (mlevel() < 2041) begin
      c = int'($urandom_range(1, 8));
      if (c > 2041 - mlevel()) c = 2041 - mlevel();
      send(c, rnd128());
    end
    valid_i = 1'b1;
    cnt_i   = 4'd8;
    data_i  = rnd128();
    #1;
    chk("bp_ready", 128'(ready_o), 128'(0));
    @(posedge clk);
    #1;
    chk("bp_we", 128'(mem_we_o), 128'(0));
    chk("bp_wp", 128'(wr_ptr_o), 128'(m_wp));
    chk("bp_err", 128'(err_o), 128'(0));
    rd_ptr = 12'd1;
    #1;
    chk("bp_ready_rise", 128'(ready_o), 128'(1));
    send(8, data_i);
    rd_ptr = 12'((m_wp - 2048) & 4095);
    #1;
    chk("full_flag", 128'(full_o), 128'(1));
    chk("full_level", 128'(level_o), 128'(2048));
    chk("full_ready", 128'(ready_o), 128'(0));

    // 5 wrap across the top of the address space
    do_clr();
    rd_ptr = '0;
    for (int i = 0; i < 255; i++) send(8, rnd128());
    send(6, rnd128());
    rd_ptr = 12'd2040;
    d = '0;
    for (int i = 0; i < 4; i++) d[16*i +: 16] = 16'(16'hA0 + i);
    send(4, d);
    chk("wrap_we", 128'(mem_we_o), 128'(8'hC3));
    chk("wrap_r6", 128'(mem_addr_o[55:48]), 128'(255));
    chk("wrap_r7", 128'(mem_addr_o[63:56]), 128'(255));
    chk("wrap_r0", 128'(mem_addr_o[7:0]), 128'(0));
    chk("wrap_r1", 128'(mem_addr_o[15:8]), 128'(0));
    chk("wrap_b6", 128'(mem_data_o[16*6 +: 16]), 128'(16'hA0));
    chk("wrap_wp", 128'(wr_ptr_o), 128'(12'h802));
    chk("wrap_level", 128'(level_o), 128'(10));

    // random words with a moving read pointer
    for (int i = 0; i < 300; i++) begin
      rd_ptr = 12'((m_wp - int'($urandom_range(0, 2048))) & 4095);
      send(int'($urandom_range(1, 8)), rnd128());
    end

    // 6 illegal counts set the sticky error
    rd_ptr = 12'(m_wp);
    c = m_wp;
    send(0, rnd128());
    send(9, rnd128());
    chk("ill_err", 128'(err_o), 128'(1));
    chk("ill_wp", 128'(wr_ptr_o), 128'(c));
    send(3, rnd128());
    chk("ill_sticky", 128'(err_o), 128'(1));
    do_clr();
    send(5, rnd128());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
